// File: rtl/serial_adder_seq_if.sv
// Request/response and adder-drive signals for serial_adder_seq.
// With SERIAL_ADDER_SEQ_CARRY_EN defined, carry_out is added to the bundle.
interface serial_adder_seq_if #(
  parameter int unsigned BIT = 4
);
  logic           start;
  logic [BIT-1:0] op_a;
  logic [BIT-1:0] op_b;
  logic           ready;
  logic           done;
  logic [BIT-1:0] sum;
  logic           adder_ctrl;
  logic [BIT-1:0] adder_a;
  logic [BIT-1:0] adder_b;
  logic [BIT-1:0] adder_result;
`ifdef SERIAL_ADDER_SEQ_CARRY_EN
  logic           carry_out;
`endif

  // Controller view: takes requests, drives the adder.
  modport slave (
    input  start, op_a, op_b, adder_result,
    output ready, done, sum, adder_ctrl, adder_a, adder_b
`ifdef SERIAL_ADDER_SEQ_CARRY_EN
    , output carry_out
`endif
  );

  // Requester/adder view.
  modport master (
    output start, op_a, op_b, adder_result,
    input  ready, done, sum, adder_ctrl, adder_a, adder_b
`ifdef SERIAL_ADDER_SEQ_CARRY_EN
    , input carry_out
`endif
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Sequencing controller for a serial_adder: load, BIT shift cycles, capture.
// Optional registered carry_out under SERIAL_ADDER_SEQ_CARRY_EN.
module serial_adder_seq #(
  parameter int unsigned BIT = 4
) (
  input logic            clk,
  input logic            reset,
  serial_adder_seq_if.slave bus
);
  localparam int unsigned CW = ($clog2(BIT) > 1) ? $clog2(BIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [BIT-1:0] r_a;
  logic [BIT-1:0] r_b;
  logic [BIT-1:0] r_sum;
  logic           r_done;
  logic           w_ctrl;
  logic           w_ready;
  logic           w_last;

  always_comb begin
    w_next  = r_state;
    w_ctrl  = 1'b0;
    w_ready = 1'b0;
    w_last  = (r_cnt == CW'(BIT - 1));
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD:    w_next = S_SHIFT;
      S_SHIFT: begin
        w_ctrl = 1'b1;
        if (w_last) w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_CAPTURE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a <= bus.op_a;
            r_b <= bus.op_b;
          end
        end
        S_LOAD:    r_cnt <= '0;
        S_SHIFT:   r_cnt <= r_cnt + CW'(1);
        S_CAPTURE: r_sum <= bus.adder_result;
        default:   ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_SEQ_CARRY_EN
  logic [BIT:0] w_full;
  logic         r_carry;

  // Carry is recomputed from the latched operands since the adder does not expose it.
  assign w_full = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_carry <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_carry <= w_full[BIT];
    end
  end

  assign bus.carry_out = r_carry;
`endif

  assign bus.ready      = w_ready;
  assign bus.done       = r_done;
  assign bus.sum        = r_sum;
  assign bus.adder_ctrl = w_ctrl;
  assign bus.adder_a    = r_a;
  assign bus.adder_b    = r_b;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq with a behavioural serial_adder beside it.
// Define SERIAL_ADDER_SEQ_CARRY_EN for both files to also check carry_out.
module tb_serial_adder_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_adder_seq_if #(.BIT(4)) bus ();

  serial_adder_seq #(.BIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Serial adder: ctrl=0 loads A/B and clears carry; ctrl=1 adds LSBs, result fills from the top.
  logic [3:0] m_a = '0;
  logic [3:0] m_b = '0;
  logic [3:0] m_res = '0;
  logic       m_c = 1'b0;
  always @(posedge clk) begin
    if (!bus.adder_ctrl) begin
      m_a <= bus.adder_a;
      m_b <= bus.adder_b;
      m_c <= 1'b0;
    end else begin
      m_a   <= m_a >> 1;
      m_b   <= m_b >> 1;
      m_c   <= (m_a[0] & m_b[0]) | (m_c & (m_a[0] ^ m_b[0]));
      m_res <= {m_a[0] ^ m_b[0] ^ m_c, m_res[3:1]};
    end
  end
  assign bus.adder_result = m_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, bus.ready, 1);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".ctrl"}, bus.adder_ctrl, 0);
  endtask

  task automatic chk_carry(input string tag, input logic exp);
`ifdef SERIAL_ADDER_SEQ_CARRY_EN
    chk({tag, ".carry"}, bus.carry_out, exp);
`else
    if (exp === 1'bx) $display("unused carry expectation for %s", tag);
`endif
  endtask

  // Full operation from an idle accept, checking every cycle through the done pulse.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] es, input logic ec);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, ".load_ready"}, bus.ready, 0);
    chk({tag, ".load_ctrl"}, bus.adder_ctrl, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, ".shift_ctrl"}, bus.adder_ctrl, 1);
      chk({tag, ".shift_ready"}, bus.ready, 0);
      chk({tag, ".shift_done"}, bus.done, 0);
    end
    tick();
    chk({tag, ".cap_ctrl"}, bus.adder_ctrl, 0);
    chk({tag, ".cap_ready"}, bus.ready, 0);
    chk({tag, ".cap_done"}, bus.done, 0);
    tick();
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".sum"}, bus.sum, es);
    chk({tag, ".ready"}, bus.ready, 1);
    chk_carry(tag, ec);
    tick();
    chk({tag, ".done_low"}, bus.done, 0);
    chk({tag, ".sum_held"}, bus.sum, es);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst.sum", bus.sum, 0);
    chk_carry("rst", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("idle");
      chk("idle.sum", bus.sum, 0);
    end

    do_op("op3p5", 4'd3, 4'd5, 4'd8, 1'b0);
    do_op("op9p9", 4'd9, 4'd9, 4'd2, 1'b1);
    do_op("op15p1", 4'd15, 4'd1, 4'd0, 1'b1);
    do_op("op1p2", 4'd1, 4'd2, 4'd3, 1'b0);

    // start held high; op_a changes mid-shift; re-accept in the done cycle.
    bus.op_a  = 4'd1;
    bus.op_b  = 4'd1;
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    bus.op_a = 4'd7;
    tick();
    tick();
    tick();
    tick();
    chk("hold.done", bus.done, 1);
    chk("hold.sum", bus.sum, 2);
    chk("hold.ready", bus.ready, 1);
    tick();
    bus.start = 1'b0;
    chk("b2b.accept_ready", bus.ready, 0);
    chk("b2b.accept_done", bus.done, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("b2b.cap_done", bus.done, 0);
    tick();
    chk("b2b.done", bus.done, 1);
    chk("b2b.sum", bus.sum, 8);
    tick();

    // Reset in the 2nd shift cycle abandons the operation.
    bus.op_a  = 4'd6;
    bus.op_b  = 4'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid.shift_ctrl", bus.adder_ctrl, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("midrst");
    chk("midrst.sum", bus.sum, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst.no_done", bus.done, 0);
    end
    do_op("op2p3", 4'd2, 4'd3, 4'd5, 1'b0);

    // start while busy is ignored.
    bus.op_a  = 4'd3;
    bus.op_b  = 4'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.op_a  = 4'd14;
    bus.op_b  = 4'd14;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("busy.done", bus.done, 1);
    chk("busy.sum", bus.sum, 7);
    chk_carry("busy", 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("busy.no_extra_done", bus.done, 0);
      chk("busy.ready", bus.ready, 1);
    end
    chk("busy.sum_held", bus.sum, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Sequencing controller for the `serial_adder` datapath (parallel-load A/B registers, LSB-first shift, carry flop cleared while its `ctrl` is low).
- Accepts one operand pair through a start/ready handshake and drives the adder's `ctrl`, `I_A` and `I_B`.
- Counts exactly `bit` shift cycles, captures the adder's `result`, then returns a registered sum with a one-cycle done pulse.
- Sits between a requesting block and one `serial_adder` instance of the same width.

Parameters:
- bit, 4, operand/result width and number of shift cycles (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- op_a  input  bit  operand A; sampled on the accepting edge
- op_b  input  bit  operand B; sampled on the accepting edge
- ready  output  1  high when state=IDLE
- done  output  1  one-cycle pulse; sum valid
- sum  output  bit  registered result (op_a+op_b) mod 2^bit; held until the next capture
- adder_ctrl  output  1  drives the adder's `ctrl` (0 = load and clear carry, 1 = shift/add)
- adder_a  output  bit  drives the adder's `I_A` (latched operand A)
- adder_b  output  bit  drives the adder's `I_B` (latched operand B)
- adder_result  input  bit  from the adder's `result`

Behaviour:
- Reset (sync, reset=1 at the edge):
  - state=IDLE; done=0; sum=0; cnt=0.
  - Latched operands = 0; adder_ctrl=0.
  - Reset has priority over start.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE.
- adder_ctrl=1 only in SHIFT; 0 in all other states, so the adder's carry flop is held clear outside SHIFT.
- IDLE:
  - ready=1.
  - start=1 at an edge: latch op_a/op_b into the adder_a/adder_b registers; go to LOAD.
  - start=0: stay in IDLE.
- LOAD:
  - One cycle; adder_ctrl=0, so the adder parallel-loads adder_a/adder_b at the closing edge.
  - Go to SHIFT with cnt=0.
- SHIFT:
  - adder_ctrl=1; cnt increments each edge.
  - At the edge where cnt=bit-1, go to CAPTURE. Exactly `bit` shift edges occur.
  - cnt width = max(1, clog2(bit)).
- CAPTURE:
  - adder_ctrl=0.
  - At the closing edge: sum <= adder_result; done <= 1; go to IDLE.
  - The adder reloads adder_a/adder_b at this same edge; this is harmless because the result was already sampled.
- done is high for exactly the one cycle following the CAPTURE edge; otherwise 0.
- Latency, taking the accept edge as E0:
  - done and the new sum are visible after edge E0+bit+2.
  - For bit=4: 6 edges after the accept edge.
- Throughput: one operation per bit+3 cycles. start may be asserted in the done cycle (ready=1 then); this is a back-to-back accept.
- start while ready=0: ignored, not queued. op_a/op_b changes while busy have no effect.
- Reset during LOAD/SHIFT/CAPTURE:
  - Operation abandoned; no done pulse; sum returns to 0.
  - adder_ctrl drops to 0, which also clears the adder carry.
- sum arithmetic: modulo 2^bit; carry-out is discarded in the base build.

Optional Feature:
- Macro: SERIAL_ADDER_SEQ_CARRY_EN.
- When defined:
  - Adds output `carry_out` (1 bit).
  - The controller keeps full-width copies of the latched operands and registers carry_out <= bit `bit` of (adder_a + adder_b) at the CAPTURE edge, alongside sum.
  - carry_out is held until the next capture; reset value is 0.
- When undefined:
  - Port and logic are absent; behaviour is otherwise identical.

Test Plan:
- reset 2 cycles, then idle 3 cycles -> ready=1, done=0, sum=0, adder_ctrl=0 throughout.
- bit=4, start with op_a=3, op_b=5 -> adder_ctrl high for exactly 4 cycles; done one cycle, 6 edges after accept; sum=8; ready low from LOAD through CAPTURE.
- bit=4, op_a=9, op_b=9 -> sum=2; with SERIAL_ADDER_SEQ_CARRY_EN, carry_out=1. Then op_a=15, op_b=1 -> sum=0, carry_out=1. Then op_a=1, op_b=2 -> sum=3, carry_out=0.
- start held high with op_a=1, op_b=1, then op_a changed to 7 mid-SHIFT -> sum=2 at done; immediate re-accept in the done cycle with the then-current op_a=7, op_b=1 -> next sum=8.
- reset asserted at the 2nd SHIFT cycle of op_a=6, op_b=6 -> no done pulse, sum=0, state IDLE next cycle. A following op_a=2, op_b=3 -> sum=5, confirming the carry was cleared.
- start pulsed while ready=0 (during SHIFT) with op_a=14, op_b=14 -> ignored; only the original operation completes, with one done pulse.
